// File: rtl/elevator_pkg.sv
// Shared defaults and FSM encoding for the elevator request scheduler.
package elevator_pkg;

  localparam int          NUM_FLOORS_DEF   = 10;
  localparam logic [31:0] DWELL_CYCLES_DEF = 32'd5000000;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SERVE_UP   = 2'd1,
    ST_SERVE_DOWN = 2'd2,
    ST_DWELL      = 2'd3
  } state_t;

endpackage

// File: rtl/floor_priority_finder.sv
// Nearest pending floor above and below the car's current floor.
module floor_priority_finder
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = NUM_FLOORS_DEF
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [3:0]            current_floor,
  output logic [3:0]            above_floor,
  output logic                  above_found,
  output logic [3:0]            below_floor,
  output logic                  below_found
);

  always_comb begin
    above_floor = '0;
    above_found = 1'b0;
    below_floor = '0;
    below_found = 1'b0;
    // high-to-low scan leaves the lowest hit above
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && (i > int'(current_floor))) begin
        above_floor = 4'(i);
        above_found = 1'b1;
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (i < int'(current_floor))) begin
        below_floor = 4'(i);
        below_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/elevator_request_scheduler.sv
// Sweep scheduler: latches floor calls and steers the car up/down
// with a door-dwell phase at every served floor.
module elevator_request_scheduler
  import elevator_pkg::*;
#(
  parameter int          NUM_FLOORS   = NUM_FLOORS_DEF,
  parameter logic [31:0] DWELL_CYCLES = DWELL_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [3:0]            current_floor,
  input  logic                  elevator_idle,
  output logic [3:0]            requested_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  direction_up,
  output logic                  dwell_active
);

  state_t                state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [3:0]            req_d;
  logic                  dir_d, dwell_d;
  logic [NUM_FLOORS-1:0] pend_d, here_mask, clr_mask;
  logic                  floor_valid, here_pend, here_call;
  logic [3:0]            above_floor, below_floor;
  logic                  above_found, below_found;

  floor_priority_finder #(
    .NUM_FLOORS(NUM_FLOORS)
  ) u_finder (
    .pending      (pending),
    .current_floor(current_floor),
    .above_floor  (above_floor),
    .above_found  (above_found),
    .below_floor  (below_floor),
    .below_found  (below_found)
  );

  always_comb begin
    here_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++)
      here_mask[i] = (int'(current_floor) == i);
  end

  assign floor_valid = int'(current_floor) < NUM_FLOORS;
  assign here_pend   = |(pending & here_mask);
  assign here_call   = |(call_req & here_mask);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = requested_floor;
    dir_d    = direction_up;
    clr_mask = '0;
    if (floor_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          req_d = current_floor;
          if (here_pend) begin
            clr_mask = here_mask;
            cnt_d    = DWELL_CYCLES;
            state_d  = ST_DWELL;
          end else if (above_found) begin
            state_d = ST_SERVE_UP;
            dir_d   = 1'b1;
            req_d   = above_floor;
          end else if (below_found) begin
            state_d = ST_SERVE_DOWN;
            dir_d   = 1'b0;
            req_d   = below_floor;
          end
        end
        ST_SERVE_UP, ST_SERVE_DOWN: begin
          if (current_floor == requested_floor) begin
            // hold target until the car reports stopped
            if (elevator_idle) begin
              clr_mask = here_mask;
              cnt_d    = DWELL_CYCLES;
              state_d  = ST_DWELL;
            end
          end else if (state_q == ST_SERVE_UP && above_found) begin
            req_d = above_floor;
          end else if (state_q == ST_SERVE_DOWN && below_found) begin
            req_d = below_floor;
          end else begin
            state_d = ST_IDLE;
            req_d   = current_floor;
          end
        end
        ST_DWELL: begin
          req_d = current_floor;
          if (here_pend || here_call) begin
            clr_mask = here_mask;
            cnt_d    = DWELL_CYCLES;
          end else if (cnt_q > 32'd1) begin
            cnt_d = cnt_q - 32'd1;
          end else begin
            cnt_d = '0;
            if (direction_up ? above_found : below_found) begin
              state_d = direction_up ? ST_SERVE_UP : ST_SERVE_DOWN;
              req_d   = direction_up ? above_floor : below_floor;
            end else if (direction_up ? below_found : above_found) begin
              dir_d   = ~direction_up;
              state_d = direction_up ? ST_SERVE_DOWN : ST_SERVE_UP;
              req_d   = direction_up ? below_floor : above_floor;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    pend_d  = (pending | call_req) & ~clr_mask;
    dwell_d = (state_d == ST_DWELL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      pending         <= '0;
      requested_floor <= '0;
      direction_up    <= 1'b1;
      dwell_active    <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pending         <= pend_d;
      requested_floor <= req_d;
      direction_up    <= dir_d;
      dwell_active    <= dwell_d;
    end
  end

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Scripted scenarios with a queue of expected per-cycle outputs.
module tb_elevator_request_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] call_req;
  logic [3:0] current_floor;
  logic       elevator_idle;
  logic [3:0] requested_floor;
  logic [9:0] pending;
  logic       direction_up;
  logic       dwell_active;

  typedef struct {
    string      tag;
    logic [3:0] rq;
    logic [9:0] pd;
    logic       dr;
    logic       dw;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  elevator_request_scheduler #(
    .NUM_FLOORS  (10),
    .DWELL_CYCLES(32'd4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .call_req       (call_req),
    .current_floor  (current_floor),
    .elevator_idle  (elevator_idle),
    .requested_floor(requested_floor),
    .pending        (pending),
    .direction_up   (direction_up),
    .dwell_active   (dwell_active)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] rq,
                      input logic [9:0] pd, input logic dr,
                      input logic dw);
    exp_t e;
    sb.push_back('{tag, rq, pd, dr, dw});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, ".req"}, 32'(requested_floor), 32'(e.rq));
    check({e.tag, ".pend"}, 32'(pending), 32'(e.pd));
    check({e.tag, ".dir"}, 32'(direction_up), 32'(e.dr));
    check({e.tag, ".dwell"}, 32'(dwell_active), 32'(e.dw));
  endtask

  task automatic step_n(input int n, input string tag,
                        input logic [3:0] rq, input logic [9:0] pd,
                        input logic dr, input logic dw);
    for (int i = 0; i < n; i++) step(tag, rq, pd, dr, dw);
  endtask

  initial begin
    rst_n = 1'b0;
    call_req = '0;
    current_floor = 4'd0;
    elevator_idle = 1'b1;
    step_n(2, "reset", 4'd0, 10'h000, 1'b1, 1'b0);
    rst_n = 1'b1;
    step_n(3, "idle", 4'd0, 10'h000, 1'b1, 1'b0);

    call_req = 10'h008;
    step("call3_latch", 4'd0, 10'h008, 1'b1, 1'b0);
    call_req = '0;
    step("call3_target", 4'd3, 10'h008, 1'b1, 1'b0);
    step("call3_travel", 4'd3, 10'h008, 1'b1, 1'b0);
    current_floor = 4'd3;
    elevator_idle = 1'b0;
    step("call3_moving", 4'd3, 10'h008, 1'b1, 1'b0);
    elevator_idle = 1'b1;
    step_n(4, "call3_dwell", 4'd3, 10'h000, 1'b1, 1'b1);
    step("call3_idle", 4'd3, 10'h000, 1'b1, 1'b0);

    current_floor = 4'd2;
    step("rt_follow", 4'd2, 10'h000, 1'b1, 1'b0);
    call_req = 10'h080;
    step("rt_latch7", 4'd2, 10'h080, 1'b1, 1'b0);
    call_req = '0;
    step("rt_target7", 4'd7, 10'h080, 1'b1, 1'b0);
    current_floor = 4'd3;
    elevator_idle = 1'b0;
    call_req = 10'h010;
    step("rt_latch4", 4'd7, 10'h090, 1'b1, 1'b0);
    call_req = '0;
    step("rt_target4", 4'd4, 10'h090, 1'b1, 1'b0);
    current_floor = 4'd4;
    elevator_idle = 1'b1;
    step_n(4, "rt_dwell4", 4'd4, 10'h080, 1'b1, 1'b1);
    step("rt_resume7", 4'd7, 10'h080, 1'b1, 1'b0);
    current_floor = 4'd7;
    step_n(4, "rt_dwell7", 4'd7, 10'h000, 1'b1, 1'b1);
    step("rt_idle", 4'd7, 10'h000, 1'b1, 1'b0);

    current_floor = 4'd5;
    step("rv_follow", 4'd5, 10'h000, 1'b1, 1'b0);
    call_req = 10'h104;
    step("rv_latch", 4'd5, 10'h104, 1'b1, 1'b0);
    call_req = '0;
    step("rv_target8", 4'd8, 10'h104, 1'b1, 1'b0);
    current_floor = 4'd8;
    step_n(4, "rv_dwell8", 4'd8, 10'h004, 1'b1, 1'b1);
    step("rv_reverse", 4'd2, 10'h004, 1'b0, 1'b0);
    current_floor = 4'd2;
    step_n(4, "rv_dwell2", 4'd2, 10'h000, 1'b0, 1'b1);
    step("rv_idle", 4'd2, 10'h000, 1'b0, 1'b0);

    current_floor = 4'd3;
    step("ro_follow", 4'd3, 10'h000, 1'b0, 1'b0);
    call_req = 10'h008;
    step("ro_latch", 4'd3, 10'h008, 1'b0, 1'b0);
    call_req = '0;
    step_n(2, "ro_dwell_a", 4'd3, 10'h000, 1'b0, 1'b1);
    call_req = 10'h008;
    step("ro_reopen", 4'd3, 10'h000, 1'b0, 1'b1);
    call_req = '0;
    step_n(3, "ro_dwell_b", 4'd3, 10'h000, 1'b0, 1'b1);
    step("ro_idle", 4'd3, 10'h000, 1'b0, 1'b0);

    current_floor = 4'd12;
    step("fz_hold", 4'd3, 10'h000, 1'b0, 1'b0);
    call_req = 10'h002;
    step("fz_latch", 4'd3, 10'h002, 1'b0, 1'b0);
    call_req = '0;
    step("fz_frozen", 4'd3, 10'h002, 1'b0, 1'b0);
    current_floor = 4'd1;
    step_n(4, "fz_dwell1", 4'd1, 10'h000, 1'b0, 1'b1);
    step("fz_idle", 4'd1, 10'h000, 1'b0, 1'b0);

    call_req = 10'h242;
    step("rs_latch", 4'd1, 10'h242, 1'b0, 1'b0);
    call_req = '0;
    step("rs_dwell1", 4'd1, 10'h240, 1'b0, 1'b1);
    rst_n = 1'b0;
    step("rs_reset", 4'd0, 10'h000, 1'b1, 1'b0);
    rst_n = 1'b1;
    step("rs_after", 4'd1, 10'h000, 1'b1, 1'b0);
    step("rs_stay", 4'd1, 10'h000, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/elevator_request_scheduler.md
ELEVATOR_REQUEST_SCHEDULER -- requirements
Module: elevator_request_scheduler

Interface
REQ-001 SHALL have parameter NUM_FLOORS, 10, number of served floors (0..NUM_FLOORS-1).
REQ-002 SHALL have parameter DWELL_CYCLES, 32'd5000000, door-dwell length in clk cycles (>=1).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port call_req  input  NUM_FLOORS  per-floor call buttons, level or pulse; high bit = request.
REQ-006 SHALL have port current_floor  input  4  floor reported by the downstream elevator state machine.
REQ-007 SHALL have port elevator_idle  input  1  high when the downstream car is stopped (its idle indication).
REQ-008 SHALL have port requested_floor  output  4  registered target floor fed to the downstream car.
REQ-009 SHALL have port pending  output  NUM_FLOORS  registered outstanding-request bitmap.
REQ-010 SHALL have port direction_up  output  1  registered sweep direction, 1 = up.
REQ-011 SHALL have port dwell_active  output  1  high while in DWELL.

Function
REQ-012 SHALL set pending[f] on the cycle after call_req[f] is sampled high; bits stay set until served.
REQ-013 SHALL implement states IDLE, SERVE_UP, SERVE_DOWN, DWELL.
REQ-014 IDLE: pending empty -> stay; pending[current_floor] set -> clear it, enter DWELL; else any pending above -> SERVE_UP; else -> SERVE_DOWN (up preferred).
REQ-015 SERVE_UP: requested_floor SHALL be the lowest pending floor > current_floor, recomputed every cycle (new nearer calls retarget).
REQ-016 SERVE_DOWN: requested_floor SHALL be the highest pending floor < current_floor, recomputed every cycle.
REQ-017 Arrival (SERVE_x, current_floor == requested_floor, elevator_idle == 1) SHALL clear pending[current_floor], load dwell counter, enter DWELL next cycle.
REQ-018 DWELL SHALL last exactly DWELL_CYCLES cycles; requested_floor held at current_floor throughout.
REQ-019 A call at current_floor during DWELL SHALL be cleared and restart the dwell count (door reopen).
REQ-020 DWELL exit: pending in direction_up sense -> continue same sweep; else pending in opposite sense -> reverse, toggle direction_up; else -> IDLE.
REQ-021 In IDLE with no pending, requested_floor SHALL equal current_floor so the car stays stopped.
REQ-022 Same-cycle set and clear of one bit SHALL resolve to clear (passenger served).
REQ-023 current_floor >= NUM_FLOORS SHALL freeze state and pending clears; new calls still latch.
REQ-024 Latency: call_req high at edge N -> pending at N+1 -> requested_floor/state at N+2.
REQ-025 Dwell counter SHALL be 32 bits, saturating never required; no wrap within DWELL_CYCLES.

Reset
REQ-026 While rst_n low at a clk edge: state IDLE, pending 0, requested_floor 0, direction_up 1, dwell_active 0, dwell counter 0.
REQ-027 Reset mid-operation SHALL discard all pending requests; no request survives reset.
REQ-028 Reset SHALL take effect only on clk rising edges (no asynchronous path).

Structure
REQ-029 Shared package elevator_pkg SHALL hold NUM_FLOORS default, DWELL_CYCLES default, and the 2-bit state encoding constants.
REQ-030 Sub-module floor_priority_finder SHALL compute lowest-set-above and highest-set-below (with found flags) from pending and current_floor, purely combinational.
REQ-031 Total RTL SHALL be 120-400 lines; requested_floor, pending, direction_up, dwell_active registered outputs.

Verification (DWELL_CYCLES = 4 for sim)
REQ-032 Reset then idle: current_floor=0, no calls -> requested_floor=0, pending=0, state IDLE indefinitely.
REQ-033 Single call: pulse call_req[3] at edge N, floor 0 -> pending=0x008 at N+1, requested_floor=3, direction_up=1 at N+2; on floor 3 + idle -> pending=0, dwell_active for 4 cycles, then IDLE.
REQ-034 Retarget: heading to 7 from floor 2, call_req[4] at floor 3 -> requested_floor becomes 4; after serving 4, continues to 7.
REQ-035 Reversal: at floor 5 going up, pending={2,8} -> serve 8, dwell, direction_up=0, requested_floor=2.
REQ-036 Dwell reopen: in DWELL at floor 3 on cycle 2, call_req[3] pulse -> dwell restarts, total dwell 2+4 cycles, pending[3] stays 0.
REQ-037 Reset mid-sweep: pending={1,6,9}, rst_n low one edge -> all outputs reset values, pending=0 next cycle.
